// File: rtl/cmd_stream_sequencer_if.sv
// Command-memory read port and matrix-payload stream of the command stream sequencer.
//   mem_rd_en / mem_addr : read strobe and word-aligned byte address to the command BRAM
//   mem_rdata            : BRAM read data, valid the cycle after mem_rd_en, held until the next read
//   mat_valid/mat_ready  : payload stream handshake toward the matrix loader
//   mat_data/idx/last    : payload word, its index, and last-word marker
// master = sequencer side, slave = memory / matrix loader side.
interface cmd_stream_sequencer_if;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mat_valid;
    logic        mat_ready;
    logic [31:0] mat_data;
    logic [3:0]  mat_idx;
    logic        mat_last;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output mat_valid, mat_data, mat_idx, mat_last,
        input  mat_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  mat_valid, mat_data, mat_idx, mat_last,
        output mat_ready
    );
endinterface

// File: rtl/cmd_stream_sequencer.sv
// Walks the command stream in the command BRAM from a start byte address, decoding
// headers into matrix-mode strobes and streaming LOAD_MATRIX payloads to the loader.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_start        : run start pulse (ignored unless idle)
//   i_base_addr    : byte address of the first header (bits [1:0] ignored)
//   o_busy/o_done  : run in progress / one-cycle end-of-run pulse
//   o_err          : sticky error, cleared by an accepted start
//   o_cmd_count    : commands executed this run (END excluded)
//   o_mode_we/sel  : matrix-mode strobe and value
//   bus            : BRAM read port and payload stream (master side)
module cmd_stream_sequencer #(
    parameter int unsigned MEM_WORDS = 26,
    parameter int unsigned MAT_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [31:0]           i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [15:0]           o_cmd_count,
    output logic                  o_mode_we,
    output logic [3:0]            o_mode_sel,
    cmd_stream_sequencer_if.master bus
);
    // One spare bit above the 30-bit word pointer so a skip can never wrap.
    localparam int unsigned PTR_W  = 31;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned MODE_W = 4;

    localparam logic [7:0]       OP_MODE   = 8'h10;
    localparam logic [7:0]       OP_LOAD   = 8'h13;
    localparam logic [7:0]       OP_END    = 8'hFF;
    localparam logic [PTR_W-1:0] MEM_LIMIT = PTR_W'(MEM_WORDS);
    localparam logic [7:0]       LOAD_LEN  = 8'(MAT_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MAT_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_RD,
        S_HDR_DEC,
        S_PAY_RD,
        S_PAY_SEND,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic [CNT_W-1:0]    r_cmd_count, w_cnt_nxt;
    logic                r_mem_rd_en, w_rd_nxt;
    logic [31:0]         r_mem_addr, w_addr_nxt;
    logic                r_mode_we, w_mode_we_nxt;
    logic [MODE_W-1:0]   r_mode_sel, w_mode_sel_nxt;
    logic                r_mat_valid, w_valid_nxt;
    logic [IDX_W-1:0]    r_mat_idx, w_idx_nxt;
    logic                r_mat_last, w_last_nxt;

    logic [7:0]          w_opcode;
    logic [7:0]          w_arg;
    logic                w_pay_flag;
    logic                w_ovf;
    logic                w_unused;

    // Header fields, meaningful while decoding.
    assign w_opcode   = bus.mem_rdata[7:0];
    assign w_arg      = bus.mem_rdata[15:8];
    assign w_pay_flag = bus.mem_rdata[31];
    assign w_ovf      = (r_ptr >= MEM_LIMIT);
    assign w_unused   = ^{i_base_addr[1:0], bus.mem_rdata[30:16]};

    // Next state plus look-ahead of every registered output for the coming cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_err_nxt      = r_err;
        w_cnt_nxt      = r_cmd_count;
        w_idx_nxt      = r_mat_idx;
        w_mode_we_nxt  = 1'b0;
        w_mode_sel_nxt = r_mode_sel;
        w_rd_nxt       = 1'b0;
        w_addr_nxt     = r_mem_addr;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_valid_nxt    = 1'b0;
        w_last_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_ptr_nxt   = {1'b0, i_base_addr[31:2]};
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HDR_RD;
                end
            end
            S_HDR_RD: begin
                if (w_ovf) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_ptr_nxt   = r_ptr + PTR_W'(1);
                    w_state_nxt = S_HDR_DEC;
                end
            end
            S_HDR_DEC: begin
                if (w_opcode == OP_END) begin
                    w_state_nxt = S_DONE;
                end else if (w_opcode == OP_MODE && !w_pay_flag) begin
                    w_mode_sel_nxt = w_arg[MODE_W-1:0];
                    w_mode_we_nxt  = 1'b1;
                    w_cnt_nxt      = r_cmd_count + CNT_W'(1);
                    w_state_nxt    = S_HDR_RD;
                end else if (w_opcode == OP_LOAD && w_pay_flag && w_arg == LOAD_LEN) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_PAY_RD;
                end else begin
                    // Unknown or malformed: flag it, step over any payload unread.
                    w_err_nxt = 1'b1;
                    if (w_pay_flag) begin
                        w_ptr_nxt = r_ptr + PTR_W'(w_arg);
                    end
                    w_state_nxt = S_HDR_RD;
                end
            end
            S_PAY_RD: begin
                if (w_ovf) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_ptr_nxt   = r_ptr + PTR_W'(1);
                    w_state_nxt = S_PAY_SEND;
                end
            end
            S_PAY_SEND: begin
                if (bus.mat_ready) begin
                    if (r_mat_last) begin
                        w_cnt_nxt   = r_cmd_count + CNT_W'(1);
                        w_state_nxt = S_HDR_RD;
                    end else begin
                        w_idx_nxt   = r_mat_idx + IDX_W'(1);
                        w_state_nxt = S_PAY_RD;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A read is issued only when the read state will not hit the overflow check.
        w_rd_nxt = ((w_state_nxt == S_HDR_RD) || (w_state_nxt == S_PAY_RD)) &&
                   (w_ptr_nxt < MEM_LIMIT);
        if (w_rd_nxt) begin
            w_addr_nxt = {w_ptr_nxt[29:0], 2'b00};
        end
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_valid_nxt = (w_state_nxt == S_PAY_SEND);
        w_last_nxt  = (w_state_nxt == S_PAY_SEND) && (w_idx_nxt == IDX_LAST);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_count <= '0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mode_we   <= 1'b0;
            r_mode_sel  <= '0;
            r_mat_valid <= 1'b0;
            r_mat_idx   <= '0;
            r_mat_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_cmd_count <= w_cnt_nxt;
            r_mem_rd_en <= w_rd_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mode_we   <= w_mode_we_nxt;
            r_mode_sel  <= w_mode_sel_nxt;
            r_mat_valid <= w_valid_nxt;
            r_mat_idx   <= w_idx_nxt;
            r_mat_last  <= w_last_nxt;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_cmd_count   = r_cmd_count;
    assign o_mode_we     = r_mode_we;
    assign o_mode_sel    = r_mode_sel;
    assign bus.mem_rd_en = r_mem_rd_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mat_valid = r_mat_valid;
    assign bus.mat_idx   = r_mat_idx;
    assign bus.mat_last  = r_mat_last;
    // BRAM output is held until the next read, which only follows the handshake.
    assign bus.mat_data  = bus.mem_rdata;
endmodule

// File: tb/tb_cmd_stream_sequencer.sv
// Self-checking bench for cmd_stream_sequencer: table of run scenarios plus
// hand-written reset/restart sequences, with a beat/mode scoreboard.
module tb_cmd_stream_sequencer;
    localparam int unsigned MEM_WORDS = 26;
    localparam int unsigned MAT_WORDS = 16;
    localparam int          CYC_LIMIT = 400;
    localparam int          NVEC      = 6;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        busy, done, err, mode_we;
    logic [15:0] cmd_count;
    logic [3:0]  mode_sel;

    cmd_stream_sequencer_if u_if();

    cmd_stream_sequencer #(.MEM_WORDS(MEM_WORDS), .MAT_WORDS(MAT_WORDS)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_cmd_count (cmd_count),
        .o_mode_we   (mode_we),
        .o_mode_sel  (mode_sel),
        .bus         (u_if)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    typedef struct {
        int img;
        int base_w;
        bit stall;
        int poke;
        bit start_on_done;
        int exp_done;
        int exp_cnt;
        bit exp_err;
        int exp_beats;
    } vec_t;

    int          total;
    int          bad;
    beat_t       beat_q[$];
    logic [3:0]  mode_q[$];
    logic [31:0] mem [MEM_WORDS];
    int          stall_plan [MAT_WORDS];
    int          stall_sum;
    vec_t        vecs [NVEC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command BRAM model: registered read, held until the next strobe.
    always @(posedge clk) begin
        if (u_if.mem_rd_en) begin
            if ((u_if.mem_addr >> 2) < 32'(MEM_WORDS))
                u_if.mem_rdata <= mem[int'(u_if.mem_addr >> 2)];
            else
                u_if.mem_rdata <= 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] payload(input int i);
        if (i == 0) return 32'h4201_3333;
        if (i == int'(MAT_WORDS) - 1) return 32'h4180_0000;
        return 32'h3F80_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input int img, input int base_w, input bit stall, input int poke,
                                input bit sod, input int exp_done, input int exp_cnt,
                                input bit exp_err, input int exp_beats);
        vec_t v;
        v.img = img; v.base_w = base_w; v.stall = stall; v.poke = poke;
        v.start_on_done = sod; v.exp_done = exp_done; v.exp_cnt = exp_cnt;
        v.exp_err = exp_err; v.exp_beats = exp_beats;
        return v;
    endfunction

    // Builds a memory image and pushes the beats/modes it must produce.
    task automatic load_image(input int img, input int b);
        beat_t e;
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h0000_00FF;
        beat_q.delete();
        mode_q.delete();
        case (img)
            0: begin
                mem[b]     = 32'h0000_0010;
                mem[b + 1] = 32'h0000_0110;
                mem[b + 2] = 32'h8000_1013;
                for (int i = 0; i < int'(MAT_WORDS); i++) begin
                    mem[b + 3 + i] = payload(i);
                    e.data = payload(i);
                    e.idx  = 4'(i);
                    e.last = (i == int'(MAT_WORDS) - 1);
                    beat_q.push_back(e);
                end
                mem[b + 19] = 32'h0000_00FF;
                mode_q.push_back(4'd0);
                mode_q.push_back(4'd1);
            end
            1: begin
                mem[b] = 32'h8000_0813;
                for (int i = 1; i <= 8; i++) mem[b + i] = 32'h0000_0010;
                mem[b + 9] = 32'h0000_00FF;
            end
            2: begin
                for (int i = 0; i < int'(MEM_WORDS); i++) begin
                    mem[i] = 32'h0000_0010 | (32'(i % 16) << 8);
                    mode_q.push_back(4'(i % 16));
                end
            end
            default: begin
                mem[b]     = 32'h0000_0055;
                mem[b + 1] = 32'h0000_0310;
                mem[b + 2] = 32'h0000_00FF;
                mode_q.push_back(4'd3);
            end
        endcase
    endtask

    // Applies one table row; caller is at a negedge with the DUT idle.
    task automatic run_case(input vec_t v);
        int          cyc;
        int          beats;
        int          stall_left;
        bit          seen_done;
        bit          stalled;
        logic [31:0] hold_data;
        logic [3:0]  hold_idx;
        beat_t       e;
        load_image(v.img, v.base_w);
        stall_sum = 0;
        for (int b = 0; b < int'(MAT_WORDS); b++) begin
            stall_plan[b] = !v.stall ? 0 : (b == 4) ? 5 : int'($urandom_range(0, 2));
            stall_sum += stall_plan[b];
        end
        base_addr  = 32'(v.base_w * 4) | 32'h3;
        start      = 1'b1;
        u_if.mat_ready = 1'b1;
        cyc = 0; beats = 0; seen_done = 0; stalled = 0;
        stall_left = stall_plan[0];
        hold_data = '0; hold_idx = '0;
        while (!seen_done && cyc < CYC_LIMIT) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (v.poke > 1 && cyc == v.poke) begin
                start = 1'b1; base_addr = 32'h40;
            end else if (v.poke > 1 && cyc == v.poke + 1) begin
                start = 1'b0;
            end
            if (u_if.mem_rd_en)
                check("mem_addr_range", 64'(u_if.mem_addr < 32'(4 * MEM_WORDS)), 64'd1);
            if (mode_we) begin
                if (mode_q.size() == 0) check("mode_we_extra", 64'd1, 64'd0);
                else check("mode_sel", 64'(mode_sel), 64'(mode_q.pop_front()));
            end
            if (stalled) begin
                check("stall_valid", 64'(u_if.mat_valid), 64'd1);
                check("stall_data", 64'(u_if.mat_data), 64'(hold_data));
                check("stall_idx", 64'(u_if.mat_idx), 64'(hold_idx));
            end
            stalled = 0;
            if (u_if.mat_valid) begin
                if (stall_left > 0) begin
                    stall_left--;
                    u_if.mat_ready = 1'b0;
                    stalled   = 1;
                    hold_data = u_if.mat_data;
                    hold_idx  = u_if.mat_idx;
                end else begin
                    u_if.mat_ready = 1'b1;
                    if (beat_q.size() == 0) begin
                        check("beat_extra", 64'd1, 64'd0);
                    end else begin
                        e = beat_q.pop_front();
                        check("beat", 64'({u_if.mat_data, u_if.mat_idx, u_if.mat_last}), 64'(e));
                    end
                    beats++;
                    if (beats < int'(MAT_WORDS)) stall_left = stall_plan[beats];
                end
            end else begin
                u_if.mat_ready = 1'b1;
            end
            if (done) seen_done = 1;
        end
        if (!seen_done) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("done_cycle", 64'(cyc), 64'(v.exp_done + stall_sum));
            check("cmd_count", 64'(cmd_count), 64'(v.exp_cnt));
            check("err", 64'(err), 64'(v.exp_err));
            check("busy_at_done", 64'(busy), 64'd1);
        end
        check("beats", 64'(beats), 64'(v.exp_beats));
        check("beats_left", 64'(beat_q.size()), 64'd0);
        check("modes_left", 64'(mode_q.size()), 64'd0);
        if (v.start_on_done) begin
            start = 1'b1; base_addr = 32'h40;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 64'(done), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_cnt"}, 64'(cmd_count), 64'd0);
        check({tag, "_rd"}, 64'({u_if.mem_rd_en, u_if.mem_addr}), 64'd0);
        check({tag, "_mode"}, 64'({mode_we, mode_sel}), 64'd0);
        check({tag, "_mat"}, 64'({u_if.mat_valid, u_if.mat_idx, u_if.mat_last}), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  found;
        total = 0; bad = 0;
        start = 1'b0; base_addr = '0; u_if.mat_ready = 1'b1;
        rst_n = 1'b0;
        vecs[0] = mk(0, 0, 0, 0,  0, 41, 3,  0, 16);  // nominal
        vecs[1] = mk(0, 0, 1, 10, 0, 41, 3,  0, 16);  // backpressure + start while busy
        vecs[2] = mk(1, 0, 0, 0,  0, 5,  0,  1, 0);   // malformed LOAD_MATRIX, skip 8
        vecs[3] = mk(3, 4, 0, 0,  1, 7,  1,  1, 0);   // unknown opcode, offset base, start on done
        vecs[4] = mk(0, 0, 0, 0,  0, 41, 3,  0, 16);  // start right after done, err cleared
        vecs[5] = mk(2, 0, 0, 0,  0, 54, 26, 1, 0);   // overflow without END

        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_case(vecs[i]);

        // Reset in the middle of beat 7.
        load_image(0, 0);
        base_addr = 32'h0;
        start = 1'b1;
        cyc = 0; found = 0;
        while (!found && cyc < CYC_LIMIT) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            u_if.mat_ready = 1'b1;
            if (u_if.mat_valid && u_if.mat_idx == 4'd7) found = 1;
        end
        check("reach_beat7", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_no_done", 64'({done, busy}), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_case(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
